// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop sync, per-button debounce, sticky press events, priority code with ack.
// Optional BTN_REPEAT_EN: held buttons re-raise their event every REPEAT_CYCLES.
module btn_debounce #(
  parameter int unsigned N_BTN         = 5,
  parameter int unsigned DB_CYCLES     = 250000,
  parameter int unsigned CNT_W         = 18,
  parameter int unsigned REPEAT_CYCLES = 12500000
) (
  input  logic             mclk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn,
  input  logic             evt_ack,
  output logic [N_BTN-1:0] btn_level,
  output logic             evt_valid,
  output logic [2:0]       btn_code,
  output logic [N_BTN-1:0] evt_pend
);

  localparam int unsigned CODE_W = 3;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  if (((DB_CYCLES >> CNT_W) != 0) || (REPEAT_CYCLES < 2)) begin : g_param_chk
    $error("btn_debounce: CNT_W too narrow for DB_CYCLES or REPEAT_CYCLES < 2");
  end

  logic [N_BTN-1:0]  r_sync1;
  logic [N_BTN-1:0]  r_sync2;
  logic [CNT_W-1:0]  r_cnt [N_BTN];
  logic [N_BTN-1:0]  r_level;
  logic [N_BTN-1:0]  r_pend;

  logic [N_BTN-1:0]  w_rise;
  logic [N_BTN-1:0]  w_rpt;
  logic [N_BTN-1:0]  w_set;
  logic [N_BTN-1:0]  w_clr;
  logic [CODE_W-1:0] w_code;

  // A level rises when the synced input has differed for DB_CYCLES edges and is now high
  always_comb begin
    w_rise = '0;
    for (int i = 0; i < N_BTN; i++) begin
      w_rise[i] = r_sync2[i] && !r_level[i] && (r_cnt[i] == DB_LAST);
    end
  end

`ifdef BTN_REPEAT_EN
  localparam int unsigned RPT_W = $clog2(REPEAT_CYCLES);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

  logic [RPT_W-1:0] r_rpt [N_BTN];

  always_comb begin
    w_rpt = '0;
    for (int i = 0; i < N_BTN; i++) begin
      w_rpt[i] = r_level[i] && (r_rpt[i] == RPT_LAST);
    end
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_BTN; i++) r_rpt[i] <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (!r_level[i] || w_rise[i] || w_rpt[i]) begin
          r_rpt[i] <= '0;
        end else begin
          r_rpt[i] <= r_rpt[i] + RPT_W'(1);
        end
      end
    end
  end
`else
  assign w_rpt = '0;
`endif

  assign w_set = w_rise | w_rpt;

  // Lowest pending index wins; 7 means idle
  always_comb begin
    w_code = CODE_W'(7);
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (r_pend[i]) w_code = CODE_W'(i);
    end
  end

  // Isolate the lowest set bit; an ack with nothing pending clears nothing
  assign w_clr = evt_ack ? (r_pend & (~r_pend + N_BTN'(1))) : '0;

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_level <= '0;
      r_pend  <= '0;
      for (int i = 0; i < N_BTN; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
      for (int i = 0; i < N_BTN; i++) begin
        if (r_sync2[i] == r_level[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DB_LAST) begin
          r_level[i] <= r_sync2[i];
          r_cnt[i]   <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
      // Set beats clear when a press lands on its own ack
      r_pend <= (r_pend & ~w_clr) | w_set;
    end
  end

  assign btn_level = r_level;
  assign evt_pend  = r_pend;
  assign evt_valid = |r_pend;
  assign btn_code  = w_code;

endmodule

// File: tb/tb_btn_debounce.sv
// Randomized self-checking bench for btn_debounce against a window-based behavioural model.
module tb_btn_debounce;

  localparam int unsigned N   = 5;
  localparam int unsigned DB  = 4;
  localparam int unsigned RPT = 20;

  logic         mclk = 1'b0;
  logic         rst_n;
  logic [N-1:0] btn;
  logic         evt_ack;
  logic [N-1:0] btn_level;
  logic         evt_valid;
  logic [2:0]   btn_code;
  logic [N-1:0] evt_pend;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: pin history (index 0 = newest edge), level, pending, held-edge counts
  logic [N-1:0] m_hist [0:7];
  logic [N-1:0] m_level;
  logic [N-1:0] m_pend;
  int           m_held [N];

  btn_debounce #(
    .N_BTN(N), .DB_CYCLES(DB), .CNT_W(3), .REPEAT_CYCLES(RPT)
  ) dut (
    .mclk(mclk), .rst_n(rst_n), .btn(btn), .evt_ack(evt_ack),
    .btn_level(btn_level), .evt_valid(evt_valid), .btn_code(btn_code), .evt_pend(evt_pend)
  );

  always #5 mclk = ~mclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] exp_code(input logic [N-1:0] p);
    for (int i = 0; i < N; i++) if (p[i]) return 3'(i);
    return 3'd7;
  endfunction

  task automatic model_reset();
    for (int j = 0; j < 8; j++) m_hist[j] = '0;
    m_level = '0;
    m_pend  = '0;
    for (int i = 0; i < N; i++) m_held[i] = 0;
  endtask

  // Level flips once the pin value seen 2..2+DB-1 edges ago has disagreed with it throughout
  task automatic model_edge(input logic [N-1:0] b, input logic a);
    logic [N-1:0] nl;
    logic [N-1:0] set;
    logic [N-1:0] clr;
    logic         diff;
    for (int j = 7; j > 0; j--) m_hist[j] = m_hist[j-1];
    m_hist[0] = b;
    nl  = m_level;
    set = '0;
    clr = '0;
    for (int i = 0; i < N; i++) begin
      diff = 1'b1;
      for (int j = 2; j < 2 + DB; j++) if (m_hist[j][i] == m_level[i]) diff = 1'b0;
      if (diff) begin
        nl[i] = ~m_level[i];
        if (nl[i]) set[i] = 1'b1;
      end
`ifdef BTN_REPEAT_EN
      if (m_level[i]) begin
        m_held[i]++;
        if (m_held[i] % RPT == 0) set[i] = 1'b1;
      end else begin
        m_held[i] = 0;
      end
`endif
    end
    if (a && m_pend != '0) clr[exp_code(m_pend)] = 1'b1;
    m_pend  = (m_pend & ~clr) | set;
    m_level = nl;
  endtask

  task automatic tick();
    @(posedge mclk);
    if (rst_n) model_edge(btn, evt_ack);
    else       model_reset();
    #1;
    check("level", 32'(btn_level), 32'(m_level));
    check("pend",  32'(evt_pend),  32'(m_pend));
    check("valid", 32'(evt_valid), 32'(m_pend != '0));
    check("code",  32'(btn_code),  32'(exp_code(m_pend)));
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  int n_ev;
  logic [5:0] bounce;

  initial begin
    rst_n   = 1'b0;
    btn     = 5'b11111;
    evt_ack = 1'b0;
    model_reset();
    ticks(3);
    check("rst_level", 32'(btn_level), 32'h0);
    check("rst_pend",  32'(evt_pend),  32'h0);
    check("rst_valid", 32'(evt_valid), 32'h0);
    check("rst_code",  32'(btn_code),  32'h7);

    // Held through reset release: level and events appear on the 6th edge
    rst_n = 1'b1;
    ticks(5);
    check("rel_level5", 32'(btn_level), 32'h0);
    tick();
    check("rel_level6", 32'(btn_level), 32'h1f);
    check("rel_pend6",  32'(evt_pend),  32'h1f);

    btn = '0;
    for (int k = 0; k < 5; k++) begin
      evt_ack = 1'b1;
      tick();
    end
    evt_ack = 1'b0;
    ticks(8);
    check("drain_valid", 32'(evt_valid), 32'h0);

    // Bounce on btn[2]
    bounce = 6'b101101;
    for (int j = 0; j < 6; j++) begin
      btn[2] = bounce[j];
      tick();
      check("bounce_lvl", 32'(btn_level[2]), 32'h0);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      check("bounce_hold", 32'(btn_level[2]), 32'h0);
    end
    tick();
    check("bounce_rise", 32'(btn_level[2]), 32'h1);
    check("bounce_code", 32'(btn_code), 32'h2);
    evt_ack = 1'b1;
    tick();
    evt_ack = 1'b0;
    btn[2]  = 1'b0;
    ticks(8);
    check("bounce_single", 32'(evt_valid), 32'h0);

    // Priority between simultaneous presses
    btn = 5'b01010;
    ticks(6);
    check("prio_first", 32'(btn_code), 32'h1);
    evt_ack = 1'b1;
    tick();
    check("prio_second", 32'(btn_code), 32'h3);
    tick();
    check("prio_empty_v", 32'(evt_valid), 32'h0);
    check("prio_empty_c", 32'(btn_code), 32'h7);
    tick();
    check("idle_ack_pend", 32'(evt_pend), 32'h0);
    evt_ack = 1'b0;
    btn = '0;
    ticks(8);

    // Second rise of btn[0] lands on the ack edge
    btn[0] = 1'b1;
    ticks(6);
    check("coll_first", 32'(evt_pend), 32'h1);
    btn[0] = 1'b0;
    ticks(8);
    btn[0] = 1'b1;
    ticks(5);
    evt_ack = 1'b1;
    tick();
    evt_ack = 1'b0;
    check("coll_level", 32'(btn_level[0]), 32'h1);
    check("coll_pend",  32'(evt_pend[0]),  32'h1);
    check("coll_valid", 32'(evt_valid),    32'h1);
    evt_ack = 1'b1;
    tick();
    evt_ack = 1'b0;
    btn = '0;
    ticks(8);

    // Asynchronous reset mid-debounce
    btn[2] = 1'b1;
    ticks(6);
    btn[4] = 1'b1;
    ticks(4);
    check("mid_pend_pre", 32'(evt_pend), 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_level", 32'(btn_level), 32'h0);
    check("mid_pend",  32'(evt_pend),  32'h0);
    check("mid_valid", 32'(evt_valid), 32'h0);
    check("mid_code",  32'(btn_code),  32'h7);
    tick();
    btn   = '0;
    rst_n = 1'b1;
    ticks(8);

    // Held btn[4]: count delivered events while acking each one
    n_ev   = 0;
    btn[4] = 1'b1;
    for (int k = 0; k < 86; k++) begin
      if (k == 76) btn[4] = 1'b0;
      evt_ack = evt_valid;
      if (evt_valid && btn_code == 3'd4) n_ev++;
      tick();
    end
    evt_ack = 1'b0;
`ifdef BTN_REPEAT_EN
    check("hold_events", 32'(n_ev), 32'd4);
`else
    check("hold_events", 32'(n_ev), 32'd1);
`endif

    // Random pins with glitches and random acks
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 15) == 0) btn[i] = ~btn[i];
      evt_ack = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
Conditions the five raw push-button inputs before they reach the io block and the CPU.
- Each button is synchronised to mclk, then debounced with a per-button stability counter.
- Each clean press becomes a sticky pending event.
- Pending events are presented as a priority-encoded code with a valid/ack handshake, so the CPU consumes exactly one event per press.
- Sits between the board pins (btn) and io/regfile; runs on the undivided mclk.

Parameters:
- N_BTN, 5, number of buttons (fixed 5 in this design; code width is 3).
- DB_CYCLES, 250000, consecutive mclk cycles the synchronised input must hold a new value before the debounced level changes (10 ms at 25 MHz).
- CNT_W, 18, width of each debounce counter; must satisfy 2^CNT_W > DB_CYCLES.
- REPEAT_CYCLES, 12500000, auto-repeat interval in mclk cycles; used only with BTN_REPEAT_EN.

Ports:
- mclk  in  1  master clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- btn  in  N_BTN  raw button pins, active-high, asynchronous to mclk.
- evt_ack  in  1  one-cycle pulse from the consumer; retires the currently presented event.
- btn_level  out  N_BTN  debounced button levels.
- evt_valid  out  1  high while at least one event is pending.
- btn_code  out  3  index of the lowest-numbered pending event; 3'd7 when none is pending.
- evt_pend  out  N_BTN  raw pending-event vector, for debug and io display.

Behaviour:
- Reset (asynchronous, rst_n=0): sync flops, counters, btn_level and evt_pend all 0. evt_valid=0, btn_code=3'd7. Reset mid-debounce discards partial counts; no event is generated on release of reset.
- Synchroniser: 2 flops per bit. The value at btn appears at the sync output 2 mclk edges later.
- Debounce, per bit i, each mclk edge:
  - If sync[i]==btn_level[i]: cnt[i]<=0.
  - Else if cnt[i]==DB_CYCLES-1: btn_level[i]<=sync[i] and cnt[i]<=0.
  - Else: cnt[i]<=cnt[i]+1.
  - A glitch shorter than DB_CYCLES resets the count and never changes the level.
  - Pin-to-level latency for a clean edge is 2+DB_CYCLES cycles.
- Event capture: a 0->1 transition of btn_level[i] sets evt_pend[i] on the same edge the level updates. A 1->0 transition (release) generates no event. A press on an already-pending bit leaves it pending; events are not counted.
- Outputs:
  - evt_valid = |evt_pend.
  - btn_code = lowest i with evt_pend[i]=1, else 7.
  - Both are combinational from evt_pend.
- Handshake:
  - evt_ack with evt_valid=1 clears evt_pend[btn_code] on that edge.
  - evt_ack with evt_valid=0 is ignored.
  - If a new press on the same bit lands on the same edge as its ack, the set wins and the bit stays pending.
  - Presses on other bits are unaffected by the ack.
  - The consumer sees the next code on the following cycle.
- Simultaneous presses: both bits become pending and are served lowest index first, one ack each.

Optional Feature:
BTN_REPEAT_EN
- Defined: each button has a repeat counter that clears when btn_level[i]=0 or at the press edge, and increments while btn_level[i]=1. When it reaches REPEAT_CYCLES-1, evt_pend[i] is set again and the counter restarts. Holding a button therefore yields one event per REPEAT_CYCLES after the initial press. Ack and set collisions follow the same set-wins rule.
- Undefined: no repeat counters are built, and a held button produces exactly one event.

Test Plan (DB_CYCLES=4, REPEAT_CYCLES=20 in simulation):
- Reset: drive rst_n=0 with btn=5'b11111 -> btn_level=0, evt_pend=0, evt_valid=0, btn_code=7. Release reset and hold btn -> btn_level=5'b11111 exactly 6 edges later, and evt_pend=5'b11111 on that same edge.
- Bounce on btn[2]: pattern 1,0,1,1,0,1 (one cycle each), then held 1 -> no level change during the bounce; btn_level[2]=1 and btn_code=2 exactly 6 edges after the final 0->1; single event; release gives no new event.
- Priority: press btn[3] and btn[1] together -> btn_code=1. Ack -> btn_code=3 next cycle. Ack -> evt_valid=0, btn_code=7. Extra ack while idle -> no change.
- Collision: btn[0] pending, btn_code=0, and a second btn[0] level rise lands on the same edge as evt_ack -> evt_pend[0] stays 1 and evt_valid stays 1.
- Reset mid-operation: assert rst_n low while cnt[4]=2 and evt_pend=5'b00100 -> all state clears immediately, asynchronously before the next edge.
- With BTN_REPEAT_EN, hold btn[4] for 70 cycles after level rise, acking each event -> 4 events: press plus repeats at +20, +40, +60. Without the macro -> 1 event.
